// File: rtl/soc_bus_pkg.sv
// Shared data-bus definitions: target encoding, default address map and decode helper.
package soc_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned TGT_W  = 2;

  typedef enum logic [TGT_W-1:0] {
    TGT_DMEM   = 2'd0,
    TGT_PERIPH = 2'd1,
    TGT_ERR    = 2'd2
  } bus_target_e;

  localparam logic [ADDR_W-1:0] DMEM_BASE_DEF   = 32'h0010_0000;
  localparam logic [ADDR_W-1:0] DMEM_MASK_DEF   = 32'hFFFF_E000;
  localparam logic [ADDR_W-1:0] PERIPH_BASE_DEF = 32'h2000_0000;
  localparam logic [ADDR_W-1:0] PERIPH_MASK_DEF = 32'hFFFF_0000;

  // DMEM is checked first so it wins on overlapping regions.
  function automatic bus_target_e decode_target(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] dmem_base,
    input logic [ADDR_W-1:0] dmem_mask,
    input logic [ADDR_W-1:0] periph_base,
    input logic [ADDR_W-1:0] periph_mask
  );
    bus_target_e tgt;
    tgt = TGT_ERR;
    if ((addr & dmem_mask) == dmem_base) begin
      tgt = TGT_DMEM;
    end else if ((addr & periph_mask) == periph_base) begin
      tgt = TGT_PERIPH;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/CORE_DATA_INF.sv
// Core data-port bus: request with address/write payload, grant, and in-order read response.
interface CORE_DATA_INF;
  import soc_bus_pkg::*;

  logic              data_req;
  logic              data_gnt;
  logic              data_we;
  logic [BE_W-1:0]   data_be;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;

  modport Master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport Slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );

endinterface

// File: rtl/resp_order_fifo.sv
// Small in-order FIFO recording which target owes the next response.
module resp_order_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] tail
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] tail_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign tail  = tail_q;

  // A pop frees the slot a simultaneous push on full writes into.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tail_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        tail_q   <= wdata;
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && empty));
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/core_data_router.sv
// Routes core LSU requests to DMEM, the peripheral bus or an internal error
// responder, and returns responses to the core in issue order.
module core_data_router
  import soc_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DMEM_BASE       = DMEM_BASE_DEF,
  parameter logic [ADDR_W-1:0] DMEM_MASK       = DMEM_MASK_DEF,
  parameter logic [ADDR_W-1:0] PERIPH_BASE     = PERIPH_BASE_DEF,
  parameter logic [ADDR_W-1:0] PERIPH_MASK     = PERIPH_MASK_DEF,
  parameter int unsigned       MAX_OUTSTANDING = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  CORE_DATA_INF.Slave  core_inf_i,
  output logic         core_err_o,
  CORE_DATA_INF.Master dmem_inf_o,
  CORE_DATA_INF.Master periph_inf_o
);

  bus_target_e       req_tgt;
  bus_target_e       head_tgt;
  bus_target_e       tail_tgt;
  logic [TGT_W-1:0]  head_raw;
  logic [TGT_W-1:0]  tail_raw;
  logic              fifo_full;
  logic              fifo_empty;
  logic              issue_ok;
  logic              slave_gnt;
  logic              core_gnt;
  logic              push;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              err_rvalid_q;

  assign req_tgt = decode_target(core_inf_i.data_addr, DMEM_BASE, DMEM_MASK,
                                 PERIPH_BASE, PERIPH_MASK);

  // Never switch targets while responses are pending, so order is implicit.
  assign issue_ok = rst_ni && !fifo_full && (fifo_empty || (tail_tgt == req_tgt));

  assign dmem_inf_o.data_addr    = core_inf_i.data_addr;
  assign dmem_inf_o.data_we      = core_inf_i.data_we;
  assign dmem_inf_o.data_be      = core_inf_i.data_be;
  assign dmem_inf_o.data_wdata   = core_inf_i.data_wdata;
  assign dmem_inf_o.data_req     = core_inf_i.data_req && issue_ok && (req_tgt == TGT_DMEM);

  assign periph_inf_o.data_addr  = core_inf_i.data_addr;
  assign periph_inf_o.data_we    = core_inf_i.data_we;
  assign periph_inf_o.data_be    = core_inf_i.data_be;
  assign periph_inf_o.data_wdata = core_inf_i.data_wdata;
  assign periph_inf_o.data_req   = core_inf_i.data_req && issue_ok && (req_tgt == TGT_PERIPH);

  always_comb begin
    slave_gnt = 1'b0;
    case (req_tgt)
      TGT_DMEM:   slave_gnt = dmem_inf_o.data_gnt;
      TGT_PERIPH: slave_gnt = periph_inf_o.data_gnt;
      default:    slave_gnt = 1'b1;
    endcase
  end

  assign core_gnt            = issue_ok && slave_gnt;
  assign core_inf_i.data_gnt = core_gnt;
  assign push                = core_inf_i.data_req && core_gnt;

  resp_order_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TGT_W)
  ) u_resp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (rsp_valid),
    .wdata  (req_tgt),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head_raw),
    .tail   (tail_raw)
  );

  assign head_tgt = bus_target_e'(head_raw);
  assign tail_tgt = bus_target_e'(tail_raw);

  // Only the head target may complete; anything else is dropped.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    if (!fifo_empty) begin
      case (head_tgt)
        TGT_DMEM: begin
          rsp_valid = dmem_inf_o.data_rvalid;
          rsp_rdata = dmem_inf_o.data_rdata;
        end
        TGT_PERIPH: begin
          rsp_valid = periph_inf_o.data_rvalid;
          rsp_rdata = periph_inf_o.data_rdata;
        end
        default: rsp_valid = err_rvalid_q;
      endcase
    end
  end

  assign core_inf_i.data_rvalid = rsp_valid;
  assign core_inf_i.data_rdata  = rsp_rdata;
  assign core_err_o             = !fifo_empty && (head_tgt == TGT_ERR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_rvalid_q <= 1'b0;
    end else begin
      err_rvalid_q <= push && (req_tgt == TGT_ERR);
    end
  end

  // With nothing outstanding, a slave rvalid is an orphan of a reset and is tolerated.
  a_dmem_rvalid_is_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (!fifo_empty && dmem_inf_o.data_rvalid) |-> (head_tgt == TGT_DMEM));
  a_periph_rvalid_is_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (!fifo_empty && periph_inf_o.data_rvalid) |-> (head_tgt == TGT_PERIPH));

endmodule

// File: tb/tb_core_data_router.sv
// Directed bench for core_data_router with a response scoreboard and delay-configurable slave models.
module tb_core_data_router;
  import soc_bus_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic core_err;
  always #5 clk = ~clk;

  CORE_DATA_INF core_if();
  CORE_DATA_INF dmem_if();
  CORE_DATA_INF periph_if();

  core_data_router #(
    .DMEM_BASE       (32'h0010_0000),
    .DMEM_MASK       (32'hFFFF_E000),
    .PERIPH_BASE     (32'h2000_0000),
    .PERIPH_MASK     (32'hFFFF_0000),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .core_inf_i   (core_if),
    .core_err_o   (core_err),
    .dmem_inf_o   (dmem_if),
    .periph_inf_o (periph_if)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   dmem_dly = 0;
  int   periph_dly = 0;
  int   dmem_reqs = 0;
  int   periph_reqs = 0;
  int   stale_drops = 0;
  int   max_occ = 0;
  logic        cap_dmem_req, cap_periph_req;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata, cap_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input int s, input logic [31:0] a, input logic we);
    if (we) return 32'h0;
    if (s == 0) return (a == 32'h0010_0004) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    return 32'h5EED_0000 | {16'h0, a[15:0]};
  endfunction

  // Slave models: registered grant, response dly cycles after the cycle following the handshake.
  always @(posedge clk) cyc <= cyc + 1;

  int d_due[$];  logic [31:0] d_dat[$];
  int p_due[$];  logic [31:0] p_dat[$];

  always @(posedge clk) begin
    if (dmem_if.data_req && dmem_if.data_gnt) begin
      d_due.push_back(cyc + dmem_dly);
      d_dat.push_back(slave_data(0, dmem_if.data_addr, dmem_if.data_we));
    end
    dmem_if.data_gnt    <= dmem_if.data_req;
    dmem_if.data_rvalid <= 1'b0;
    if (d_due.size() > 0 && d_due[0] <= cyc) begin
      dmem_if.data_rvalid <= 1'b1;
      dmem_if.data_rdata  <= d_dat.pop_front();
      void'(d_due.pop_front());
    end
  end

  always @(posedge clk) begin
    if (periph_if.data_req && periph_if.data_gnt) begin
      p_due.push_back(cyc + periph_dly);
      p_dat.push_back(slave_data(1, periph_if.data_addr, periph_if.data_we));
    end
    periph_if.data_gnt    <= periph_if.data_req;
    periph_if.data_rvalid <= 1'b0;
    if (p_due.size() > 0 && p_due[0] <= cyc) begin
      periph_if.data_rvalid <= 1'b1;
      periph_if.data_rdata  <= p_dat.pop_front();
      void'(p_due.pop_front());
    end
  end

  // Monitor: pops the scoreboard on every core response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_if.data_rvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rvalid: rdata 0x%08h with no response expected", core_if.data_rdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_rdata", core_if.data_rdata, mon_e.rdata);
          check("rsp_err", 32'(core_err), 32'(mon_e.err));
        end
      end
      if (periph_if.data_rvalid && !core_if.data_rvalid) stale_drops++;
      if (dmem_if.data_req) dmem_reqs++;
      if (periph_if.data_req) periph_reqs++;
      if (int'(dut.u_resp_fifo.count_q) > max_occ) max_occ = int'(dut.u_resp_fifo.count_q);
    end
  end

  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input logic expect_rsp,
                       input logic [31:0] exp_rd, input logic exp_err, output int waited);
    exp_t e;
    core_if.data_req   = 1'b1;
    core_if.data_addr  = a;
    core_if.data_we    = we;
    core_if.data_be    = be;
    core_if.data_wdata = wd;
    if (expect_rsp) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      exp_q.push_back(e);
    end
    waited = 0;
    @(negedge clk);
    cap_dmem_req   = dmem_if.data_req;
    cap_periph_req = periph_if.data_req;
    cap_be         = periph_if.data_be;
    cap_wdata      = periph_if.data_wdata;
    cap_addr       = periph_if.data_addr;
    while (!core_if.data_gnt && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (!core_if.data_gnt) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout: no grant for addr 0x%08h after %0d cycles", a, waited);
    end
    @(posedge clk);
    #1;
    core_if.data_req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d responses still outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n              = 1'b0;
    core_if.data_req   = 1'b1;
    core_if.data_addr  = 32'h0010_0004;
    core_if.data_we    = 1'b0;
    core_if.data_be    = 4'hF;
    core_if.data_wdata = 32'h0;

    // Reset values, with a request already pending at the core.
    idle(2);
    check("rst_gnt", 32'(core_if.data_gnt), 32'd0);
    check("rst_rvalid", 32'(core_if.data_rvalid), 32'd0);
    check("rst_rdata", core_if.data_rdata, 32'd0);
    check("rst_err", 32'(core_err), 32'd0);
    check("rst_dmem_req", 32'(dmem_if.data_req), 32'd0);
    check("rst_periph_req", 32'(periph_if.data_req), 32'd0);
    core_if.data_req = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // DMEM read.
    dmem_reqs = 0; periph_reqs = 0;
    issue(32'h0010_0004, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, w);
    check("dmem_gnt_wait", 32'(w), 32'd1);
    wait_drain("dmem_read");
    check("dmem_read_periph_reqs", 32'(periph_reqs), 32'd0);
    idle(3);

    // Peripheral write with partial byte enables.
    dmem_reqs = 0;
    issue(32'h2000_0010, 1'b1, 4'b0011, 32'h1234_5678, 1'b1, 32'h0, 1'b0, w);
    check("pw_periph_req", 32'(cap_periph_req), 32'd1);
    check("pw_dmem_req", 32'(cap_dmem_req), 32'd0);
    check("pw_be", 32'(cap_be), 32'h3);
    check("pw_wdata", cap_wdata, 32'h1234_5678);
    check("pw_addr", cap_addr, 32'h2000_0010);
    check("pw_gnt_wait", 32'(w), 32'd1);
    wait_drain("periph_write");
    check("pw_dmem_reqs", 32'(dmem_reqs), 32'd0);
    idle(3);

    // Unmapped address answered by the error responder.
    dmem_reqs = 0; periph_reqs = 0;
    issue(32'h4000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1, w);
    check("err_gnt_wait", 32'(w), 32'd0);
    wait_drain("err_access");
    check("err_dmem_reqs", 32'(dmem_reqs), 32'd0);
    check("err_periph_reqs", 32'(periph_reqs), 32'd0);
    idle(3);

    // Target switch blocked until the slow peripheral response pops.
    periph_dly = 3;
    issue(32'h2000_0020, 1'b0, 4'hF, 32'h0, 1'b1, 32'h5EED_0020, 1'b0, w);
    check("sw_periph_gnt_wait", 32'(w), 32'd1);
    issue(32'h0010_0008, 1'b0, 4'hF, 32'h0, 1'b1, 32'hA5B5_0008, 1'b0, w);
    check("sw_dmem_gnt_wait", 32'(w), 32'd5);
    wait_drain("target_switch");
    idle(3);

    // Back-to-back DMEM reads stall at full occupancy.
    dmem_dly = 2; max_occ = 0;
    issue(32'h0010_0008, 1'b0, 4'hF, 32'h0, 1'b1, 32'hA5B5_0008, 1'b0, w);
    check("b2b_r1_gnt_wait", 32'(w), 32'd1);
    issue(32'h0010_000C, 1'b0, 4'hF, 32'h0, 1'b1, 32'hA5B5_000C, 1'b0, w);
    check("b2b_r2_gnt_wait", 32'(w), 32'd0);
    issue(32'h0010_0010, 1'b0, 4'hF, 32'h0, 1'b1, 32'hA5B5_0010, 1'b0, w);
    check("b2b_r3_gnt_wait", 32'(w), 32'd3);
    wait_drain("back_to_back");
    check("b2b_max_occupancy", 32'(max_occ), 32'd2);
    dmem_dly = 0;
    idle(3);

    // Reset with a peripheral read outstanding; its late response must be dropped.
    periph_dly = 4; stale_drops = 0;
    issue(32'h2000_0030, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, w);
    core_if.data_req  = 1'b1;
    core_if.data_addr = 32'h2000_0040;
    rst_n = 1'b0;
    #1;
    check("mrst_gnt", 32'(core_if.data_gnt), 32'd0);
    check("mrst_rvalid", 32'(core_if.data_rvalid), 32'd0);
    check("mrst_err", 32'(core_err), 32'd0);
    check("mrst_periph_req", 32'(periph_if.data_req), 32'd0);
    core_if.data_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    check("mrst_stale_dropped", 32'(stale_drops), 32'd1);
    issue(32'h0010_000C, 1'b0, 4'hF, 32'h0, 1'b1, 32'hA5B5_000C, 1'b0, w);
    check("mrst_dmem_gnt_wait", 32'(w), 32'd1);
    wait_drain("after_reset");
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_data_router.md
# core_data_router

Address-decoding router between the CV32 core's data port and the data-side slaves. Accepts one `CORE_DATA_INF` master: the core's LSU. It forwards each request to exactly one slave `CORE_DATA_INF`: `data_memory` (DMEM) or the peripheral bus (PERIPH). Unmapped addresses are answered by an internal error responder. Responses are returned to the core in strict issue order, tracked by a small in-order response FIFO.

## Interface
Parameters:
- `DMEM_BASE`, 32'h0010_0000: DMEM region base; region is `(addr & DMEM_MASK) == DMEM_BASE`.
- `DMEM_MASK`, 32'hFFFF_E000: DMEM region mask (8 KB).
- `PERIPH_BASE`, 32'h2000_0000: peripheral region base.
- `PERIPH_MASK`, 32'hFFFF_0000: peripheral region mask (64 KB).
- `MAX_OUTSTANDING`, 2: response FIFO depth, range 1..4.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `core_inf_i`, `CORE_DATA_INF.Slave`, -: from core LSU.
- `core_err_o`, out, 1: error flag, valid with `core_inf_i.data_rvalid`.
- `dmem_inf_o`, `CORE_DATA_INF.Master`, -: to `data_memory`.
- `periph_inf_o`, `CORE_DATA_INF.Master`, -: to peripheral bus.

## Operation
- **Decode:** combinational on `data_addr`. DMEM wins if both regions match. No match means target ERR.
- **Forwarding:**
  - `addr`, `we`, `be` and `wdata` go to both slaves unchanged.
  - `data_req` is asserted only on the selected slave, and only when issue is allowed.
- **Issue allowed when all hold:**
  - FIFO not full.
  - FIFO empty, or the FIFO tail target equals the new target (no target switch while responses are pending).
- **Grant:**
  - `core.data_gnt` = issue allowed AND the selected slave's `data_gnt`.
  - For ERR, the grant is issue allowed only.
- **Push:** on every core handshake (`req & gnt`), push {target[1:0]} into the FIFO.
- **Response:**
  - The FIFO head selects which slave's `data_rvalid`/`data_rdata` drives the core.
  - `core_err_o` = head is ERR.
  - Pop on `core.data_rvalid`.
- **ERR responder:**
  - Registered.
  - Asserts rvalid exactly one cycle after the ERR handshake, with rdata = 32'h0 and err = 1.
  - Covers reads and writes.
- **Spurious rvalid:** rvalid from a slave that is not the FIFO head is ignored and does not pop. An assertion flags it in simulation.
- **Occupancy counter:** 0..MAX_OUTSTANDING.
  - Push only: +1. Pop only: −1. Push and pop in the same cycle: unchanged.
  - Overflow and underflow are impossible by construction and are asserted.

## Timing
- **Reset values:**
  - All slave `data_req` = 0.
  - `core.data_gnt` = 0; `core.data_rvalid` = 0; `core.data_rdata` = 0; `core_err_o` = 0.
  - FIFO empty, occupancy 0, ERR responder idle.
- **Request path:** fully combinational, zero added latency. Slave gnt reaches the core in the same cycle.
- **Response path:** combinational mux from slave to core, zero added latency.
- **DMEM example:** gnt and rvalid are registered by `data_memory` one cycle after req. The core therefore sees gnt and rvalid in the same cycle. Push and pop in that cycle keep occupancy constant.
- **ERR:** gnt in the req cycle; rvalid on the next cycle.
- **Stall:** when issue is blocked, slave req = 0 and core gnt = 0. The core holds its request; the router holds no state for it.
- **Mid-transaction reset:** the FIFO is flushed asynchronously. Late slave rvalids arriving after reset release are dropped as spurious.

## Structure
- `soc_bus_pkg`: `bus_target_e` {TGT_DMEM, TGT_PERIPH, TGT_ERR}, default base/mask localparams. `soc_config_pkg` imports the map constants from it.
- Sub-module `resp_order_fifo`:
  - Parameterized depth and width.
  - Outputs full, empty and head.
  - Pointer wrap by modulo depth; handles push+pop on full and on empty.
- Decode, issue gating and the ERR responder live in `core_data_router`.

## Test plan
- Read at 0x0010_0004, DMEM returns 0xDEADBEEF one cycle later → core gets gnt, then rvalid with rdata 0xDEADBEEF and err = 0; periph req never asserted.
- Write to 0x2000_0010, be = 4'b0011 → only `periph_inf_o.data_req` rises, with be 0011 and wdata passed through; rvalid returned, err = 0.
- Access to 0x4000_0000 → gnt in the same cycle, rvalid next cycle with rdata 0, `core_err_o` = 1; neither slave sees req.
- Periph read pending (slave delays rvalid 3 cycles), core issues a DMEM read → core gnt held 0 until the periph response pops; then the DMEM request issues. Responses arrive in order.
- Back-to-back DMEM reads with MAX_OUTSTANDING = 2 and a slave that delays rvalid → third request stalls at full. Occupancy never exceeds 2; push+pop cycle keeps occupancy at 2.
- Reset asserted with one periph read outstanding → outputs go to 0 immediately. A stale rvalid after release is not forwarded; the next DMEM read completes normally.
